regfile_nr1w: RTL and testbench

Parametrised register file with one synchronous write port and `NRD` independent read ports, replacing per-port fixed 32-way read multiplexers in the RISC-V datapath. Register 0 is hardwired to zero. Same-cycle write-to-read bypass is available, and read ports are optionally registered. Sits between instruction decode (addresses) and the ALU operand muxes (data).

---
 rtl/regfile_nr1w_pkg.sv | 13 +
 rtl/regfile_nr1w_if.sv | 17 +
 rtl/regfile_nr1w_regmux_p.sv | 17 +
 rtl/regfile_nr1w.sv | 68 ++++++
 tb/tb_regfile_nr1w.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/regfile_nr1w_pkg.sv
// rtl/regfile_nr1w_pkg.sv - shared widths, zero-register index and packed-port slicing
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 0;

  // Port k of a packed multi-port bus occupies bits [k*w +: w].
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_nr1w_if.sv
// rtl/regfile_nr1w_if.sv - write port and packed read ports of the register file
interface regfile_nr1w_if import rv_pkg::*; #(
  parameter int N   = XLEN,
  parameter int A   = REG_AW,
  parameter int NRD = 2
);

  logic             we;
  logic [A-1:0]     waddr;
  logic [N-1:0]     wdata;
  logic [NRD*A-1:0] raddr;
  logic [NRD*N-1:0] rdata;

  modport master (output we, output waddr, output wdata, output raddr, input rdata);
  modport slave  (input we, input waddr, input wdata, input raddr, output rdata);

endinterface

// File: rtl/regfile_nr1w_regmux_p.sv
// rtl/regfile_nr1w_regmux_p.sv - 2**A:1 read select with index 0 forced to zero
module regmux_p import rv_pkg::*; #(
  parameter int N = XLEN,
  parameter int A = REG_AW
) (
  input  logic [A-1:0]          sel,
  input  logic [(1<<A)*N-1:0]   words,
  output logic [N-1:0]          dout
);

  always_comb begin
    dout = '0;
    if (sel != A'(ZERO_REG))
      dout = words[int'(sel)*N +: N];
  end

endmodule

// File: rtl/regfile_nr1w.sv
// rtl/regfile_nr1w.sv - N-read 1-write register file, x0 hardwired, optional bypass and read register
module regfile_nr1w import rv_pkg::*; #(
  parameter int N      = XLEN,
  parameter int A      = REG_AW,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int RD_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  regfile_nr1w_if.slave bus
);

  localparam int DEPTH = 1 << A;

  logic [N-1:0]       mem [1:DEPTH-1];
  logic [DEPTH*N-1:0] mem_flat;
  logic [NRD*N-1:0]   rv_all;
  logic               wr_en;

  assign wr_en = bus.we && (bus.waddr != A'(ZERO_REG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < DEPTH; r++)
        mem[r] <= '0;
    end else if (wr_en) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    mem_flat = '0;
    for (int r = 1; r < DEPTH; r++)
      mem_flat[r*N +: N] = mem[r];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [A-1:0] ra;
    logic [N-1:0] sel_d;

    assign ra = bus.raddr[port_lsb(k, A) +: A];

    regmux_p #(.N(N), .A(A)) u_mux (
      .sel   (ra),
      .words (mem_flat),
      .dout  (sel_d)
    );

    // wr_en already excludes x0; bypass is masked in reset so rdata stays zero.
    assign rv_all[port_lsb(k, N) +: N] =
      ((BYPASS != 0) && wr_en && !rst && (ra == bus.waddr)) ? bus.wdata : sel_d;
  end

  if (RD_REG != 0) begin : g_rdreg
    logic [NRD*N-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rv_all;
    end

    assign bus.rdata = rdata_q;
  end else begin : g_rdcomb
    assign bus.rdata = rv_all;
  end

endmodule

// File: tb/tb_regfile_nr1w.sv
// tb/tb_regfile_nr1w.sv - scoreboard bench over three register file configurations
module tb_regfile_nr1w;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: bypass, combinational, 2 ports. b: no bypass, registered, 3 ports. c: 8-bit x 8, bypass, registered, 1 port.
  regfile_nr1w_if #(.N(32), .A(5), .NRD(2)) ifa ();
  regfile_nr1w_if #(.N(32), .A(5), .NRD(3)) ifb ();
  regfile_nr1w_if #(.N(8),  .A(3), .NRD(1)) ifc ();

  regfile_nr1w #(.N(32), .A(5), .NRD(2), .BYPASS(1), .RD_REG(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_nr1w #(.N(32), .A(5), .NRD(3), .BYPASS(0), .RD_REG(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  regfile_nr1w #(.N(8),  .A(3), .NRD(1), .BYPASS(1), .RD_REG(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] m32 [32];
  logic [7:0]  m8  [8];

  logic [63:0] qa [$];
  logic [95:0] qb [$];
  logic [7:0]  qc [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp32(input logic [4:0] r, input bit we, input logic [4:0] wa,
                                        input logic [31:0] wd, input bit byp);
    if (r == 5'd0) return 32'd0;
    if (byp && we && wa != 5'd0 && r == wa) return wd;
    return m32[r];
  endfunction

  function automatic logic [7:0] exp8(input logic [2:0] r, input bit we, input logic [2:0] wa,
                                      input logic [7:0] wd);
    if (r == 3'd0) return 8'd0;
    if (we && wa != 3'd0 && r == wa) return wd;
    return m8[r];
  endfunction

  // One cycle: drive at posedge+1, compare at negedge, retire model write at posedge.
  task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    ifa.we = we; ifa.waddr = wa; ifa.wdata = wd; ifa.raddr = {r1, r0};
    ifb.we = we; ifb.waddr = wa; ifb.wdata = wd; ifb.raddr = {r2, r1, r0};
    ifc.we = we; ifc.waddr = wa[2:0]; ifc.wdata = wd[7:0]; ifc.raddr = r0[2:0];
    qa.push_back({exp32(r1, we, wa, wd, 1'b1), exp32(r0, we, wa, wd, 1'b1)});
    qb.push_back({exp32(r2, we, wa, wd, 1'b0), exp32(r1, we, wa, wd, 1'b0), exp32(r0, we, wa, wd, 1'b0)});
    qc.push_back(exp8(r0[2:0], we, wa[2:0], wd[7:0]));
    @(negedge clk);
    chk("a_comb_bypass", 128'(ifa.rdata), 128'(qa.pop_front()));
    if (qb.size() > 1) chk("b_reg_nobypass", 128'(ifb.rdata), 128'(qb.pop_front()));
    if (qc.size() > 1) chk("c_n8_reg_bypass", 128'(ifc.rdata), 128'(qc.pop_front()));
    @(posedge clk);
    if (we && wa != 5'd0) m32[wa] = wd;
    if (we && wa[2:0] != 3'd0) m8[wa[2:0]] = wd[7:0];
    #1;
  endtask

  // Reset asserted mid-cycle with a write to r5 in flight and every port reading r5.
  task automatic do_reset();
    ifa.we = 1'b1; ifa.waddr = 5'd5; ifa.wdata = 32'h1234_5678; ifa.raddr = {5'd5, 5'd5};
    ifb.we = 1'b1; ifb.waddr = 5'd5; ifb.wdata = 32'h1234_5678; ifb.raddr = {5'd5, 5'd5, 5'd5};
    ifc.we = 1'b1; ifc.waddr = 3'd5; ifc.wdata = 8'h78;         ifc.raddr = 3'd5;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_a", 128'(ifa.rdata), 128'd0);
    chk("rst_async_b", 128'(ifb.rdata), 128'd0);
    chk("rst_async_c", 128'(ifc.rdata), 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_a", 128'(ifa.rdata), 128'd0);
    chk("rst_hold_b", 128'(ifb.rdata), 128'd0);
    chk("rst_hold_c", 128'(ifc.rdata), 128'd0);
    ifa.we = 1'b0; ifb.we = 1'b0; ifc.we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m32[i] = 32'd0;
    for (int i = 0; i < 8; i++)  m8[i]  = 8'd0;
    qa.delete(); qb.delete(); qc.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // x0 immutability, including bypass configurations
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0,         5'd0, 5'd0, 5'd0);

    // write all with concurrent reads, then read back ascending/descending
    for (int i = 1; i < 32; i++)
      step(1'b1, 5'(i), 32'h1000 + 32'(i), 5'(i), 5'(32 - i), 5'(i));
    for (int i = 1; i < 32; i++)
      step(1'b0, 5'd0, 32'd0, 5'(i), 5'(32 - i), 5'(i));

    // bypass on r7
    step(1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'd0,  5'd7, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'd0,  5'd7, 5'd7, 5'd7);

    // all ports on r9 while r10 is written
    step(1'b1, 5'd9,  32'hCAFE, 5'd0,  5'd0,  5'd0);
    step(1'b1, 5'd10, 32'hBEEF, 5'd9,  5'd9,  5'd9);
    step(1'b0, 5'd0,  32'd0,    5'd10, 5'd10, 5'd10);
    step(1'b0, 5'd0,  32'd0,    5'd9,  5'd10, 5'd0);

    // narrow configuration: r7 <- 0xA5, r0, then idle cycle
    step(1'b1, 5'd7, 32'hA5, 5'd7, 5'd0, 5'd7);
    step(1'b0, 5'd7, 32'h5A, 5'd7, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'd0,  5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0,  5'd7, 5'd0, 5'd0);

    // random traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           5'($urandom), 5'($urandom), 5'($urandom));

    // reset clears stored data
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0,         5'd5, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0,         5'd5, 5'd5, 5'd5);
    do_reset();
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    step(1'b1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
